// File: rtl/genius_pkg.sv
// ---------------------------------------------------------------------------
// genius_pkg
// Shared definitions for the Genius round sequencer slice.
//   - Round FSM state encodings (IDLE=0 .. FAIL=6, 7 is illegal)
//   - Widths of the button vector, sequence numbers, lookup index, counters
//   - btnIndex(): encodes a one-hot button vector to the number it selects
// ---------------------------------------------------------------------------
package genius_pkg;

  localparam int NUM_BTN = 3;
  localparam int NUM_W   = 2;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHOW_ON  = 3'd1,
    ST_SHOW_GAP = 3'd2,
    ST_WAIT_REL = 3'd3,
    ST_INPUT    = 3'd4,
    ST_DONE     = 3'd5,
    ST_FAIL     = 3'd6
  } state_t;

  // Encodes a button vector to the index of its highest set bit. Only
  // meaningful when the vector is one-hot; callers qualify it themselves.
  function automatic logic [NUM_W-1:0] btnIndex(input logic [NUM_BTN-1:0] btn);
    logic [NUM_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (btn[i]) idx = NUM_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/genius_round_sequencer_if.sv
// ---------------------------------------------------------------------------
// genius_round_sequencer_if
// Bundle between the top-level game FSM (master) and the round sequencer
// (slave).
//   master drives : start, level, btn, seq_num (registered lookup output)
//   slave drives  : seq_idx, display_en, input_en, press_valid, press_ok,
//                   round_done, fail, timed_out, state_dbg
// ---------------------------------------------------------------------------
interface genius_round_sequencer_if;
  import genius_pkg::*;

  logic               start;
  logic [IDX_W-1:0]   level;
  logic [NUM_BTN-1:0] btn;
  logic [NUM_W-1:0]   seq_num;

  logic [IDX_W-1:0]   seq_idx;
  logic               display_en;
  logic               input_en;
  logic               press_valid;
  logic               press_ok;
  logic               round_done;
  logic               fail;
  logic               timed_out;
  logic [2:0]         state_dbg;

  modport master (
    output start, level, btn, seq_num,
    input  seq_idx, display_en, input_en, press_valid, press_ok,
           round_done, fail, timed_out, state_dbg
  );

  modport slave (
    input  start, level, btn, seq_num,
    output seq_idx, display_en, input_en, press_valid, press_ok,
           round_done, fail, timed_out, state_dbg
  );

endinterface

// File: rtl/genius_btn_arbiter.sv
// ---------------------------------------------------------------------------
// genius_btn_arbiter
// Combinational evaluation of the player buttons against the expected number.
//   i_btn     : synchronized buttons, btn[i] selects number i
//   i_seqNum  : number expected for the current item
//   o_press   : any button is down
//   o_correct : exactly one button is down and it selects i_seqNum
// ---------------------------------------------------------------------------
module genius_btn_arbiter
  import genius_pkg::*;
(
  input  logic [NUM_BTN-1:0] i_btn,
  input  logic [NUM_W-1:0]   i_seqNum,
  output logic               o_press,
  output logic               o_correct
);

  logic w_oneHot;

  // Clearing the lowest set bit leaves zero only for a single-button press,
  // so chords are rejected as wrong rather than resolved by priority.
  assign w_oneHot  = (i_btn != '0) && ((i_btn & (i_btn - 1'b1)) == '0);
  assign o_press   = (i_btn != '0);
  assign o_correct = w_oneHot && (btnIndex(i_btn) == i_seqNum);

endmodule

// File: rtl/genius_round_sequencer.sv
// ---------------------------------------------------------------------------
// genius_round_sequencer
// Timing and control FSM for one Genius round: plays back items 0..level
// with programmable on/gap times, then collects one button press per item
// with a per-press timeout, and reports done/fail to the game FSM.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high, clears all state
//   bus   : slave side of genius_round_sequencer_if (see that file)
// All outputs are registered.
// ---------------------------------------------------------------------------
module genius_round_sequencer
  import genius_pkg::*;
#(
  parameter int unsigned SHOW_TICKS    = 50,
  parameter int unsigned GAP_TICKS     = 10,
  parameter int unsigned TIMEOUT_TICKS = 500
) (
  input logic                      clock,
  input logic                      reset,
  genius_round_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] SHOW_LAST    = CNT_W'(SHOW_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

  state_t           r_state;
  logic             r_startQ;
  logic [IDX_W-1:0] r_levelQ;
  logic [IDX_W-1:0] r_seqIdx;
  logic [CNT_W-1:0] r_tick;
  logic [CNT_W-1:0] r_timeout;
  logic             r_displayEn;
  logic             r_inputEn;
  logic             r_pressValid;
  logic             r_pressOk;
  logic             r_roundDone;
  logic             r_fail;
  logic             r_timedOut;

  logic w_startEdge;
  logic w_press;
  logic w_correct;

  assign w_startEdge = bus.start & ~r_startQ;

  genius_btn_arbiter u_arbiter (
    .i_btn     (bus.btn),
    .i_seqNum  (bus.seq_num),
    .o_press   (w_press),
    .o_correct (w_correct)
  );

  // Round FSM. Strobes and the display/input enables default to 0 every
  // cycle and are set only on the transitions that lead into a cycle where
  // they must be high, so each output is already aligned with r_state.
  // display_en stays low on tick 0 of every show window because seq_num
  // for a freshly changed seq_idx is not valid until one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_startQ     <= 1'b0;
      r_levelQ     <= '0;
      r_seqIdx     <= '0;
      r_tick       <= '0;
      r_timeout    <= '0;
      r_displayEn  <= 1'b0;
      r_inputEn    <= 1'b0;
      r_pressValid <= 1'b0;
      r_pressOk    <= 1'b0;
      r_roundDone  <= 1'b0;
      r_fail       <= 1'b0;
      r_timedOut   <= 1'b0;
    end else begin
      r_startQ     <= bus.start;
      r_displayEn  <= 1'b0;
      r_inputEn    <= 1'b0;
      r_pressValid <= 1'b0;
      r_pressOk    <= 1'b0;
      r_roundDone  <= 1'b0;
      r_fail       <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_startEdge) begin
            r_levelQ   <= bus.level;
            r_seqIdx   <= '0;
            r_tick     <= '0;
            r_timedOut <= 1'b0;
            r_state    <= ST_SHOW_ON;
          end
        end

        ST_SHOW_ON: begin
          if (r_tick == SHOW_LAST) begin
            r_tick  <= '0;
            r_state <= ST_SHOW_GAP;
          end else begin
            r_tick      <= r_tick + 1'b1;
            r_displayEn <= 1'b1;
          end
        end

        ST_SHOW_GAP: begin
          if (r_tick == GAP_LAST) begin
            r_tick <= '0;
            if (r_seqIdx == r_levelQ) begin
              r_seqIdx <= '0;
              r_state  <= ST_WAIT_REL;
            end else begin
              r_seqIdx <= r_seqIdx + 1'b1;
              r_state  <= ST_SHOW_ON;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        // Also the cycle in which seq_num catches up with a new seq_idx.
        ST_WAIT_REL: begin
          if (bus.btn == '0) begin
            r_timeout <= '0;
            r_inputEn <= 1'b1;
            r_state   <= ST_INPUT;
          end
        end

        // A press is checked before the timeout so a press landing on the
        // final allowed cycle still counts.
        ST_INPUT: begin
          if (w_press) begin
            r_pressValid <= 1'b1;
            r_pressOk    <= w_correct;
            if (w_correct && (r_seqIdx == r_levelQ)) begin
              r_roundDone <= 1'b1;
              r_state     <= ST_DONE;
            end else if (w_correct) begin
              r_seqIdx <= r_seqIdx + 1'b1;
              r_state  <= ST_WAIT_REL;
            end else begin
              r_fail  <= 1'b1;
              r_state <= ST_FAIL;
            end
          end else if (r_timeout == TIMEOUT_LAST) begin
            r_timedOut <= 1'b1;
            r_fail     <= 1'b1;
            r_state    <= ST_FAIL;
          end else begin
            r_timeout <= r_timeout + 1'b1;
            r_inputEn <= 1'b1;
          end
        end

        ST_DONE: r_state <= ST_IDLE;
        ST_FAIL: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.seq_idx     = r_seqIdx;
  assign bus.display_en  = r_displayEn;
  assign bus.input_en    = r_inputEn;
  assign bus.press_valid = r_pressValid;
  assign bus.press_ok    = r_pressOk;
  assign bus.round_done  = r_roundDone;
  assign bus.fail        = r_fail;
  assign bus.timed_out   = r_timedOut;
  assign bus.state_dbg   = r_state;

endmodule

// File: doc/genius_round_sequencer.md
Name: genius_round_sequencer

Overview:
- Timing and control FSM for one Genius round.
- Drives the sequence-lookup index and display enable during playback with programmable on/gap times.
- Arbitrates the three player buttons during the input phase and enforces a per-press timeout.
- Reports done/fail to the top-level game FSM, which owns level progression and the LED/7-segment outputs.

Parameters:
- SHOW_TICKS, 50, cycles each item is held in the show window (range 2..65535)
- GAP_TICKS, 10, blank cycles between items (range 1..65535)
- TIMEOUT_TICKS, 500, cycles allowed per press before fail (range 2..65535)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  level signal; the rising edge starts a round
- level  in  4  round length minus 1 (items 0..level); sampled on the start edge
- btn  in  3  synchronized buttons, active-high; btn[i] selects number i
- seq_num  in  2  number at seq_idx, from the registered lookup (1-cycle latency)
- seq_idx  out  4  lookup index
- display_en  out  1  show seq_num on the display
- input_en  out  1  player input window open
- press_valid  out  1  1-cycle pulse, a press was evaluated
- press_ok  out  1  qualifies press_valid; 1 means correct
- round_done  out  1  1-cycle pulse, all items entered correctly
- fail  out  1  1-cycle pulse, wrong press or timeout
- timed_out  out  1  sticky; set on timeout fail, cleared on the next start edge
- state_dbg  out  3  current state encoding

Behaviour:
- All outputs registered. Reset clears every output and internal register to 0; state goes to IDLE.
- Internals: start_q edge register, level_q (4b), tick counter (16b), timeout counter (16b).
- State IDLE (0): all strobes 0.
  - On start & ~start_q: level_q <= level, seq_idx <= 0, tick <= 0, timed_out <= 0, go to SHOW_ON.
  - Start edges outside IDLE are ignored. Changes to level after the start edge are ignored.
- State SHOW_ON (1): tick counts 0..SHOW_TICKS-1.
  - display_en = 1 for tick >= 1; the first cycle is suppressed to cover lookup latency.
  - At tick == SHOW_TICKS-1: tick <= 0, go to SHOW_GAP.
- State SHOW_GAP (2): display_en = 0 for GAP_TICKS cycles. At the last gap cycle:
  - If seq_idx == level_q: seq_idx <= 0, go to WAIT_REL.
  - Else: seq_idx <= seq_idx+1, go to SHOW_ON.
- State WAIT_REL (3): input_en = 0. Stays until btn == 3'b000 is sampled, then goes to INPUT with the timeout counter cleared.
  - Minimum 1 cycle, which guarantees seq_num is valid for the current seq_idx.
- State INPUT (4): input_en = 1; the timeout counter increments each cycle.
  - Any btn != 0 is a press. It is correct only if btn is one-hot and its index == seq_num.
  - Multiple buttons pressed at once counts as wrong.
  - Next cycle: press_valid = 1 and press_ok = result.
  - Correct and seq_idx == level_q: go to DONE. seq_idx is not incremented, so there is no wrap at level 15.
  - Correct otherwise: seq_idx <= seq_idx+1, go to WAIT_REL.
  - Wrong: go to FAIL.
  - Counter reaches TIMEOUT_TICKS-1 with no press: timed_out <= 1, go to FAIL.
  - Press and timeout in the same cycle: the press wins.
- State DONE (5): round_done = 1 for one cycle, then IDLE.
- State FAIL (6): fail = 1 for one cycle, then IDLE. timed_out holds.
- Encoding 7 is illegal; it goes to IDLE with all strobes 0.
- Reset asserted mid-round aborts immediately; no done/fail pulse is produced.
- Round length in cycles, show phase: (level+1)*(SHOW_TICKS+GAP_TICKS).

Decomposition:
- Shared package genius_pkg holds:
  - state encodings (IDLE=0 .. FAIL=6)
  - button width constant NUM_BTN = 3
  - number width NUM_W = 2
  - index width IDX_W = 4
- One natural sub-module: genius_btn_arbiter (combinational one-hot check + index encode + compare to seq_num, giving press/correct). Reusable by the top-level FSM.

Test Plan (SHOW_TICKS=4, GAP_TICKS=2, TIMEOUT_TICKS=20, lookup table 2,1,0,1,...):
1. level=0, start pulse:
   - display_en high 3 cycles, low 2; seq_idx stays 0.
   - Then input_en=1. Press btn=3'b100 -> press_valid & press_ok, then round_done pulse, state IDLE.
2. level=2, correct presses 100, 010, 001, each released between presses:
   - seq_idx walks 0,1,2 in show and input phases.
   - 3 press_ok pulses, round_done once, fail never.
3. level=1, first press btn=3'b010 (expects 2) -> press_valid=1, press_ok=0, fail pulse, timed_out=0, seq_idx stays 0.
4. level=0, no press for 20 cycles in INPUT -> fail pulse, timed_out=1.
   - Next start edge clears timed_out; a press on cycle 19 together with the timeout -> press evaluated, no timeout.
5. btn=3'b110 in INPUT -> wrong (fail). Button held across the accept -> WAIT_REL stalls, input_en=0 until btn=0.
6. reset asserted during SHOW_GAP, level=15 round -> all outputs 0 asynchronously.
   - After release, a start pulse and 16 correct presses -> round_done, seq_idx ends at 15 (no wrap).
